// File: rtl/decode_scoreboard.sv
// Decode stage with a per-register pending-write scoreboard; all state updates on the falling clock edge.
// Optional WB_BYPASS_EN: the hazard check discounts a writeback that retires in the same cycle.
module decode_scoreboard #(
  parameter int unsigned PC_WIDTH   = 16,
  parameter int unsigned IR_WIDTH   = 32,
  parameter int unsigned NUM_REGS   = 16,
  parameter int unsigned CNT_WIDTH  = 2,
  parameter logic [7:0]  NOP_OPCODE = 8'hFF,
  parameter logic [3:0]  BR_CLASS   = 4'hC,
  parameter logic [3:0]  ST_CLASS   = 4'hB
) (
  input  logic                I_CLOCK,
  input  logic                I_RESET,
  input  logic                I_LOCK,
  input  logic [PC_WIDTH-1:0] I_PC,
  input  logic [IR_WIDTH-1:0] I_IR,
  input  logic                I_FE_Valid,
  input  logic                I_BranchAddrSelect,
  input  logic                I_GPUStallSignal,
  input  logic                I_WB_Valid,
  input  logic [3:0]          I_WB_DestReg,
  output logic                O_LOCK,
  output logic [PC_WIDTH-1:0] O_PC,
  output logic [IR_WIDTH-1:0] O_IR,
  output logic [3:0]          O_DestReg,
  output logic [3:0]          O_Src1,
  output logic [3:0]          O_Src2,
  output logic                O_DE_Valid,
  output logic                O_BranchStallSignal,
  output logic                O_DepStallSignal
);

  localparam logic [IR_WIDTH-1:0]  NopWord = {NOP_OPCODE, {(IR_WIDTH - 8){1'b0}}};
  localparam logic [CNT_WIDTH-1:0] CntMax  = '1;

  typedef enum logic [0:0] {StIdle, StBrWait} state_e;

  state_e                state_q, state_d;
  logic [CNT_WIDTH-1:0]  cnt_q   [NUM_REGS];
  logic [CNT_WIDTH-1:0]  cnt_d   [NUM_REGS];
  logic [CNT_WIDTH-1:0]  cnt_eff [NUM_REGS];
  logic                  lock_q, lock_d;
  logic [PC_WIDTH-1:0]   pc_q, pc_d;
  logic [IR_WIDTH-1:0]   ir_q, ir_d;
  logic [3:0]            dest_q, dest_d, src1_q, src1_d, src2_q, src2_d;
  logic                  valid_q, valid_d;

  logic [3:0] dest, src1, src2;
  logic       live, is_br, writes, hazard, issue;

  assign dest   = I_IR[23:20];
  assign src1   = I_IR[19:16];
  assign src2   = I_IR[11:8];
  assign live   = I_FE_Valid && (I_IR[31:24] != NOP_OPCODE);
  assign is_br  = (I_IR[31:28] == BR_CLASS);
  assign writes = live && !is_br && (I_IR[31:28] != ST_CLASS);

  // Count seen by the hazard check; with bypass a retiring write no longer blocks.
  always_comb begin
    for (int unsigned r = 0; r < NUM_REGS; r++) begin
      cnt_eff[r] = cnt_q[r];
`ifdef WB_BYPASS_EN
      if (I_WB_Valid && (I_WB_DestReg == 4'(r)) && (cnt_q[r] != '0)) begin
        cnt_eff[r] = cnt_q[r] - 1'b1;
      end
`endif
    end
  end

  assign hazard = live && ((cnt_eff[src1] != '0) || (cnt_eff[src2] != '0) ||
                           (writes && (cnt_eff[dest] == CntMax)));
  assign issue  = (state_q == StIdle) && live && !hazard && I_LOCK && !I_GPUStallSignal;

  assign O_BranchStallSignal = (state_q == StBrWait) ? 1'b1 : (live && is_br && !hazard);
  assign O_DepStallSignal    = I_FE_Valid && (hazard || I_GPUStallSignal) && (state_q == StIdle);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (issue && is_br) state_d = StBrWait;
      StBrWait: if (I_BranchAddrSelect) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    lock_d  = lock_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    dest_d  = dest_q;
    src1_d  = src1_q;
    src2_d  = src2_q;
    valid_d = valid_q;
    if (!I_GPUStallSignal) begin
      lock_d = I_LOCK;
      if (issue) begin
        pc_d    = I_PC;
        ir_d    = I_IR;
        dest_d  = dest;
        src1_d  = src1;
        src2_d  = src2;
        valid_d = 1'b1;
      end else begin
        ir_d    = NopWord;
        valid_d = 1'b0;
      end
    end
  end

  // Issue and retire to the same register in one cycle cancel out.
  always_comb begin
    logic inc, dec;
    inc = 1'b0;
    dec = 1'b0;
    for (int unsigned r = 0; r < NUM_REGS; r++) begin
      cnt_d[r] = cnt_q[r];
      inc = issue && writes && (dest == 4'(r));
      dec = I_WB_Valid && (I_WB_DestReg == 4'(r));
      if (I_LOCK) begin
        if (inc && !dec) begin
          cnt_d[r] = cnt_q[r] + 1'b1;
        end else if (dec && !inc && (cnt_q[r] != '0)) begin
          cnt_d[r] = cnt_q[r] - 1'b1;
        end
      end
    end
  end

  always_ff @(negedge I_CLOCK or posedge I_RESET) begin
    if (I_RESET) begin
      state_q <= StIdle;
      for (int unsigned r = 0; r < NUM_REGS; r++) cnt_q[r] <= '0;
      lock_q  <= 1'b0;
      pc_q    <= '0;
      ir_q    <= NopWord;
      dest_q  <= '0;
      src1_q  <= '0;
      src2_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      for (int unsigned r = 0; r < NUM_REGS; r++) cnt_q[r] <= cnt_d[r];
      lock_q  <= lock_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      dest_q  <= dest_d;
      src1_q  <= src1_d;
      src2_q  <= src2_d;
      valid_q <= valid_d;
    end
  end

  assign O_LOCK     = lock_q;
  assign O_PC       = pc_q;
  assign O_IR       = ir_q;
  assign O_DestReg  = dest_q;
  assign O_Src1     = src1_q;
  assign O_Src2     = src2_q;
  assign O_DE_Valid = valid_q;

endmodule
